// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the signed-overflow rule for a difference.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Overflow of A - B: operands differ in sign and the result sign differs from A.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: D = A - B - B_in, with borrow-out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic B_in,
    output logic D,
    output logic B_out
);

    assign D     = A ^ B ^ B_in;
    assign B_out = (~A & B) | (~(A ^ B) & B_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell and a
// registered borrow, with a start/busy/done handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; result outputs hold the last value
// ST_RUN  | one operand bit pair processed per cycle, count 0..WIDTH-1
// ST_DONE | one-cycle done pulse; start here chains the next op directly
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             V
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               b_out_q, b_out_d;
    logic               v_q, v_d;

    logic               cell_d;
    logic               cell_bo;
    logic [WIDTH-1:0]   shift_w;

    full_subtractor u_cell (
        .A     (a_sr_q[0]),
        .B     (b_sr_q[0]),
        .B_in  (borrow_q),
        .D     (cell_d),
        .B_out (cell_bo)
    );

    // Difference bits enter from the MSB side; after the last bit this is D.
    assign shift_w = {cell_d, res_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        d_d      = d_q;
        b_out_d  = b_out_q;
        v_d      = v_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_sr_d   = A;
                    b_sr_d   = B;
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d    = shift_w[WIDTH-1:1];
                borrow_d = cell_bo;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    count_d = '0;
                    state_d = ST_DONE;
                    d_d     = shift_w;
                    b_out_d = cell_bo;
                    v_d     = sub_overflow(a_msb_q, b_msb_q, cell_d);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= '0;
            b_out_q  <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            d_q      <= d_d;
            b_out_q  <= b_out_d;
            v_q      <= v_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign D     = d_q;
    assign B_out = b_out_q;
    assign V     = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepted starts push arithmetic
// expectations with their accept cycle; a negedge monitor checks handshake timing and results.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, B_out, V;
    logic [W-1:0] D;

    logic fs_a, fs_b, fs_bin, fs_d, fs_bo;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .D(D), .B_out(B_out), .V(V)
    );

    full_subtractor u_fs (
        .A(fs_a), .B(fs_b), .B_in(fs_bin), .D(fs_d), .B_out(fs_bo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         v;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accepted = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        int ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        sd = sa - sb;
        r.d   = W'((ua - ub + 2**W) % 2**W);
        r.bo  = (ua < ub);
        r.v   = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
        r.acc = 0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start = s;
        A = a;
        B = b;
        if (s && !busy && rst_n) begin
            e = ref_sub(a, b);
            e.acc = cyc + 1;
            q.push_back(e);
            accepted++;
        end
    endtask

    task automatic apply_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] ed, input logic ebo, input logic ev);
        exp_t e;
        start = 1'b1;
        A = a;
        B = b;
        check("accept_when_idle", 32'(busy), 32'd0);
        e.d = ed;
        e.bo = ebo;
        e.v = ev;
        e.acc = cyc + 1;
        q.push_back(e);
        accepted++;
    endtask

    task automatic rand_idle();
        apply(1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3 * W; i++) begin
            if (q.size() == 0) break;
            tick();
            rand_idle();
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        start = 1'b0;
        q.delete();
        last = '{d: '0, bo: 1'b0, v: 1'b0, acc: 0};
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: expected busy/done follow from the oldest pending op's accept cycle.
    always @(negedge clk) begin : monitor
        bit eb, ed;
        int el;
        if (mon_en && rst_n) begin
            eb = 1'b0;
            ed = 1'b0;
            if (q.size() > 0 && q[0].acc <= cyc) begin
                el = cyc - q[0].acc;
                eb = (el < W);
                ed = (el >= W);
            end
            check("busy", 32'(busy), 32'(eb));
            check("done", 32'(done), 32'(ed));
            if (ed) begin
                check("D", 32'(D), 32'(q[0].d));
                check("B_out", 32'(B_out), 32'(q[0].bo));
                check("V", 32'(V), 32'(q[0].v));
                last = q[0];
                void'(q.pop_front());
            end else begin
                check("D_hold", 32'(D), 32'(last.d));
                check("B_out_hold", 32'(B_out), 32'(last.bo));
                check("V_hold", 32'(V), 32'(last.v));
            end
        end
    end

    initial begin
        int r;
        int guard;
        int target;
        last = '{d: '0, bo: 1'b0, v: 1'b0, acc: 0};

        for (int i = 0; i < 8; i++) begin
            fs_a   = i[2];
            fs_b   = i[1];
            fs_bin = i[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            check("fs_D", 32'(fs_d), 32'(r & 1));
            check("fs_B_out", 32'(fs_bo), 32'(r < 0));
        end

        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;

        tick(); apply_exp(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        tick(); rand_idle();
        wait_drain();
        tick(); apply_exp(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        wait_drain();
        tick(); apply_exp(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        wait_drain();
        tick(); apply_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_drain();

        // start held high with changing operands; chain on the DONE cycle
        tick(); apply(1'b1, 8'h11, 8'h22);
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (done) begin
                apply_exp(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
                break;
            end
            apply(1'b1, W'($urandom), W'($urandom));
        end
        tick(); rand_idle();
        wait_drain();

        // reset in the middle of a run discards the op
        tick(); apply(1'b1, 8'h37, 8'h12);
        repeat (3) begin tick(); rand_idle(); end
        do_reset();
        repeat (3) begin tick(); rand_idle(); end
        tick(); apply_exp(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
        tick(); rand_idle();
        wait_drain();

        target = accepted + 1000;
        guard = 0;
        while (accepted < target && guard < 40000) begin
            tick();
            apply($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
            guard++;
        end
        check("random_ops_issued", 32'(accepted >= target), 32'd1);
        tick(); rand_idle();
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
